seg_scan_controller: RTL and testbench

- Time-multiplexed scanner for an 8-digit common-anode hex display.
- Holds a frame value and sequences digit by digit. Each cycle it presents one 4-bit nibble to the downstream hex-to-seven-segment decoder, plus a one-hot active-low anode select and a blank flag.
- New values arrive over a valid/ready handshake. They are applied only at frame boundaries, so the display never tears mid-scan.

---
 rtl/seg_scan_controller_pkg.sv | 23 ++
 rtl/seg_scan_controller_dwell_timer.sv | 49 ++++
 rtl/seg_scan_controller.sv | 118 +++++++++++
 tb/tb_seg_scan_controller.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_controller_pkg.sv
// Shared types, constants and helpers for the multiplexed hex display scanner.
// Imported by the scan controller and its dwell timer.
package seg_scan_controller_pkg;

    localparam int NUM_DIGITS_DEFAULT = 8;
    localparam int LZ_MAX_DIGITS      = 16;
    localparam int LZ_W               = 4 * LZ_MAX_DIGITS;

    typedef logic [$clog2(NUM_DIGITS_DEFAULT)-1:0] digit_idx_t;

    localparam logic [LZ_MAX_DIGITS-1:0] ANODES_OFF = '1;

    // True when every nibble at position idx and above is zero.
    function automatic logic upper_nibbles_zero(
        input logic [LZ_W-1:0] val,
        input int unsigned     idx
    );
        logic [LZ_W-1:0] shifted;
        shifted = val >> (4 * idx);
        return shifted == '0;
    endfunction

endpackage

// File: rtl/seg_scan_controller_dwell_timer.sv
// Dwell counter and digit index for the display scanner.
// Flags the final cycle of each frame.
module seg_dwell_timer #(
    parameter int  NUM_DIGITS   = 8,
    parameter int  DWELL_CYCLES = 100000,
    localparam int CNT_W        = $clog2(DWELL_CYCLES),
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    output logic [CNT_W-1:0] dwell_cnt_out,
    output logic [IDX_W-1:0] digit_idx_out,
    output logic             frame_end_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             slot_end;

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign dwell_cnt_out = cnt_q;
    assign digit_idx_out = idx_q;
    assign frame_end_out = slot_end && (idx_q == IDX_LAST);

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scanner for a common-anode hex display.
// New values are latched at frame boundaries so a scan never tears.
module seg_scan_controller
    import seg_scan_controller_pkg::*;
#(
    parameter int  NUM_DIGITS    = NUM_DIGITS_DEFAULT,
    parameter int  DWELL_CYCLES  = 100000,
    parameter int  GUARD_CYCLES  = 2,
    parameter int  BLANK_LEADING = 1,
    localparam int VAL_W         = 4 * NUM_DIGITS,
    localparam int IDX_W         = $clog2(NUM_DIGITS),
    localparam int CNT_W         = $clog2(DWELL_CYCLES)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [VAL_W-1:0]  val_in,
    input  logic              val_valid_in,
    output logic              val_ready_out,
    output logic [3:0]        nibble_out,
    output logic              blank_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic [IDX_W-1:0]  digit_idx_out
);

    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(ANODES_OFF);

    logic [CNT_W-1:0]      dwell_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic                  frame_end;

    logic [VAL_W-1:0]      pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [VAL_W-1:0]      display_q, display_d;
    logic                  val_ready_q, val_ready_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            nibble_q, nibble_d;
    logic                  blank_q, blank_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic                  xfer;
    logic                  in_guard;
    logic                  lead_zero;
    logic [NUM_DIGITS-1:0] an_lit;

    seg_dwell_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_timer (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .dwell_cnt_out (dwell_cnt),
        .digit_idx_out (digit_idx),
        .frame_end_out (frame_end)
    );

    // Ready is low on a loading boundary, so capture and load never coincide.
    always_comb begin
        xfer            = val_valid_in & val_ready_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        display_d       = display_q;
        if (frame_end && pending_valid_q) begin
            display_d       = pending_q;
            pending_valid_d = 1'b0;
        end else if (xfer) begin
            pending_d       = val_in;
            pending_valid_d = 1'b1;
        end
        val_ready_d = ~pending_valid_d;
    end

    always_comb begin
        in_guard  = (dwell_cnt < GUARD_C);
        an_lit    = '1;
        nibble_d  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                an_lit[i] = 1'b0;
                nibble_d  = display_q[4*i +: 4];
            end
        end
        lead_zero = upper_nibbles_zero(LZ_W'(display_q), 32'(digit_idx));
        an_d      = in_guard ? AN_OFF : an_lit;
        blank_d   = in_guard
                  | ((BLANK_LEADING != 0) && (digit_idx != '0) && lead_zero);
        idx_d     = digit_idx;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            display_q       <= '0;
            val_ready_q     <= 1'b0;
            an_q            <= AN_OFF;
            nibble_q        <= '0;
            blank_q         <= 1'b1;
            idx_q           <= '0;
        end else begin
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            display_q       <= display_d;
            val_ready_q     <= val_ready_d;
            an_q            <= an_d;
            nibble_q        <= nibble_d;
            blank_q         <= blank_d;
            idx_q           <= idx_d;
        end
    end

    assign val_ready_out = val_ready_q;
    assign an_out        = an_q;
    assign nibble_out    = nibble_q;
    assign blank_out     = blank_q;
    assign digit_idx_out = idx_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with a 4-digit, 8-cycle-dwell setup.
// cyc counts rising edges since reset release; frames load on multiples of 32.
module tb_seg_scan_controller;

    logic        clk_in;
    logic        rst_n_in;
    logic [15:0] val_in;
    logic        val_valid_in;
    logic        val_ready_out;
    logic [3:0]  nibble_out;
    logic        blank_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx_out;

    int total;
    int bad;
    int cyc;

    localparam logic [3:0] AN_LIT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_scan_controller #(
        .NUM_DIGITS    (4),
        .DWELL_CYCLES  (8),
        .GUARD_CYCLES  (2),
        .BLANK_LEADING (1)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .val_in        (val_in),
        .val_valid_in  (val_valid_in),
        .val_ready_out (val_ready_out),
        .nibble_out    (nibble_out),
        .blank_out     (blank_out),
        .an_out        (an_out),
        .digit_idx_out (digit_idx_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n_in     = 1'b0;
        val_valid_in = 1'b0;
        val_in       = '0;
        repeat (5) tick();
        total++;
        if (an_out !== 4'hF) begin
            bad++;
            $display("FAIL reset_an got=%h want=F", an_out);
        end
        total++;
        if (blank_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_blank got=%b want=1", blank_out);
        end
        total++;
        if (nibble_out !== 4'h0) begin
            bad++;
            $display("FAIL reset_nibble got=%h want=0", nibble_out);
        end
        total++;
        if (val_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0", val_ready_out);
        end
        total++;
        if (digit_idx_out !== 2'd0) begin
            bad++;
            $display("FAIL reset_idx got=%0d want=0", digit_idx_out);
        end
        rst_n_in = 1'b1;
        cyc      = 0;
        tick();
        total++;
        if (val_ready_out !== 1'b1 || an_out !== 4'hF || digit_idx_out !== 2'd0) begin
            bad++;
            $display("FAIL release got ready=%b an=%h idx=%0d want ready=1 an=F idx=0",
                     val_ready_out, an_out, digit_idx_out);
        end
    endtask

    task automatic test_load();
        logic [3:0] nib [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        logic [3:0] ean;
        logic       eblk;
        while (cyc < 10) tick();
        val_in       = 16'h1234;
        val_valid_in = 1'b1;
        tick();
        val_valid_in = 1'b0;
        total++;
        if (val_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL load_accept_ready cyc=%0d got=%b want=0", cyc, val_ready_out);
        end
        while (cyc < 31) begin
            tick();
            total++;
            if (val_ready_out !== 1'b0) begin
                bad++;
                $display("FAIL load_hold_ready cyc=%0d got=%b want=0", cyc, val_ready_out);
            end
        end
        tick();
        total++;
        if (val_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL load_boundary_ready cyc=%0d got=%b want=1", cyc, val_ready_out);
        end
        for (int j = 0; j < 32; j++) begin
            tick();
            ean  = (j % 8 < 2) ? 4'hF : AN_LIT[j/8];
            eblk = (j % 8 < 2);
            total++;
            if (an_out !== ean || blank_out !== eblk || nibble_out !== nib[j/8]
                || digit_idx_out !== 2'(j/8)) begin
                bad++;
                $display("FAIL load_frame cyc=%0d an=%b/%b blank=%b/%b nib=%h/%h idx=%0d/%0d",
                         cyc, an_out, ean, blank_out, eblk, nibble_out, nib[j/8],
                         digit_idx_out, j/8);
            end
        end
    endtask

    task automatic test_leading_blank();
        logic [3:0] nib_a [4] = '{4'h0, 4'h5, 4'h0, 4'h0};
        logic       blk_a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       blk_z [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] ean;
        logic       eblk;
        val_in       = 16'h0050;
        val_valid_in = 1'b1;
        tick();
        val_valid_in = 1'b0;
        while (cyc < 96) tick();
        for (int j = 0; j < 32; j++) begin
            tick();
            ean  = (j % 8 < 2) ? 4'hF : AN_LIT[j/8];
            eblk = (j % 8 < 2) ? 1'b1 : blk_a[j/8];
            total++;
            if (an_out !== ean || blank_out !== eblk || nibble_out !== nib_a[j/8]) begin
                bad++;
                $display("FAIL blank_0050 cyc=%0d an=%b/%b blank=%b/%b nib=%h/%h",
                         cyc, an_out, ean, blank_out, eblk, nibble_out, nib_a[j/8]);
            end
        end
        val_in       = 16'h0000;
        val_valid_in = 1'b1;
        tick();
        val_valid_in = 1'b0;
        while (cyc < 160) tick();
        for (int j = 0; j < 32; j++) begin
            tick();
            ean  = (j % 8 < 2) ? 4'hF : AN_LIT[j/8];
            eblk = (j % 8 < 2) ? 1'b1 : blk_z[j/8];
            total++;
            if (an_out !== ean || blank_out !== eblk || nibble_out !== 4'h0) begin
                bad++;
                $display("FAIL blank_0000 cyc=%0d an=%b/%b blank=%b/%b nib=%h/0",
                         cyc, an_out, ean, blank_out, eblk, nibble_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ean;
        logic       eblk;
        val_in       = 16'hAAAA;
        val_valid_in = 1'b1;
        tick();
        val_in = 16'hBBBB;
        total++;
        if (val_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first_ready cyc=%0d got=%b want=0", cyc, val_ready_out);
        end
        while (cyc < 223) tick();
        total++;
        if (val_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_boundary_ready cyc=%0d got=%b want=0", cyc, val_ready_out);
        end
        tick();
        total++;
        if (val_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_after_load_ready cyc=%0d got=%b want=1", cyc, val_ready_out);
        end
        for (int j = 0; j < 64; j++) begin
            tick();
            if (j == 0) begin
                val_valid_in = 1'b0;
                total++;
                if (val_ready_out !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_second_accept cyc=%0d got=%b want=0", cyc, val_ready_out);
                end
            end
            ean  = (j % 8 < 2) ? 4'hF : AN_LIT[(j/8)%4];
            eblk = (j % 8 < 2);
            total++;
            if (an_out !== ean || blank_out !== eblk
                || nibble_out !== ((j < 32) ? 4'hA : 4'hB)) begin
                bad++;
                $display("FAIL b2b_frame cyc=%0d an=%b/%b blank=%b/%b nib=%h/%h",
                         cyc, an_out, ean, blank_out, eblk, nibble_out,
                         (j < 32) ? 4'hA : 4'hB);
            end
        end
    endtask

    task automatic test_boundary_valid();
        logic [3:0] nib_c [4] = '{4'hD, 4'h0, 4'hC, 4'h0};
        logic       blk_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] ean;
        logic [3:0] enib;
        logic       eblk;
        while (cyc < 319) tick();
        val_in       = 16'h0C0D;
        val_valid_in = 1'b1;
        tick();
        val_valid_in = 1'b0;
        total++;
        if (val_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL bnd_accept_ready cyc=%0d got=%b want=0", cyc, val_ready_out);
        end
        for (int j = 0; j < 64; j++) begin
            tick();
            if (j == 31) begin
                total++;
                if (val_ready_out !== 1'b1) begin
                    bad++;
                    $display("FAIL bnd_load_ready cyc=%0d got=%b want=1", cyc, val_ready_out);
                end
            end
            ean  = (j % 8 < 2) ? 4'hF : AN_LIT[(j/8)%4];
            enib = (j < 32) ? 4'hB : nib_c[(j/8)%4];
            eblk = (j % 8 < 2) ? 1'b1 : ((j < 32) ? 1'b0 : blk_c[(j/8)%4]);
            total++;
            if (an_out !== ean || blank_out !== eblk || nibble_out !== enib) begin
                bad++;
                $display("FAIL bnd_frame cyc=%0d an=%b/%b blank=%b/%b nib=%h/%h",
                         cyc, an_out, ean, blank_out, eblk, nibble_out, enib);
            end
        end
    endtask

    task automatic test_async_reset();
        logic       blk_z [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] ean;
        logic       eblk;
        val_in       = 16'h9999;
        val_valid_in = 1'b1;
        tick();
        val_valid_in = 1'b0;
        while (cyc < 405) tick();
        total++;
        if (an_out !== 4'b1011 || nibble_out !== 4'hC) begin
            bad++;
            $display("FAIL arst_pre an=%b/1011 nib=%h/C", an_out, nibble_out);
        end
        #3;
        rst_n_in = 1'b0;
        #1;
        total++;
        if (an_out !== 4'hF || blank_out !== 1'b1 || val_ready_out !== 1'b0
            || nibble_out !== 4'h0) begin
            bad++;
            $display("FAIL arst_immediate an=%h/F blank=%b/1 ready=%b/0 nib=%h/0",
                     an_out, blank_out, val_ready_out, nibble_out);
        end
        repeat (3) tick();
        rst_n_in = 1'b1;
        cyc      = 0;
        for (int j = 0; j < 64; j++) begin
            tick();
            ean  = (j % 8 < 2) ? 4'hF : AN_LIT[(j/8)%4];
            eblk = (j % 8 < 2) ? 1'b1 : blk_z[(j/8)%4];
            total++;
            if (an_out !== ean || blank_out !== eblk || nibble_out !== 4'h0
                || digit_idx_out !== 2'((j/8)%4) || val_ready_out !== 1'b1) begin
                bad++;
                $display("FAIL arst_after cyc=%0d an=%b/%b blank=%b/%b nib=%h/0 idx=%0d/%0d ready=%b/1",
                         cyc, an_out, ean, blank_out, eblk, nibble_out,
                         digit_idx_out, (j/8)%4, val_ready_out);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        test_reset();
        test_load();
        test_leading_blank();
        test_back_to_back();
        test_boundary_valid();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
